msx_io_bus_bridge: RTL and testbench

Upstream stage of the cartridge I/O peripherals (timer block at ports B0h-B3h and siblings). Converts the asynchronous Z80 slot I/O cycle (IORQ_n/RD_n/WR_n/M1_n, A[7:0], D[7:0]) into one internal bus_valid/bus_ready transaction per Z80 cycle. Holds the Z80 via WAIT_n until the peripheral answers. Returns FFh on timeout, i.e. when no peripheral claims the port.

---
 rtl/msx_io_bus_bridge_pkg.sv | 15 +
 rtl/msx_slot_sync.sv | 28 ++
 rtl/msx_io_bus_bridge.sv | 177 +++++++++++++++++
 tb/tb_msx_io_bus_bridge.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/msx_io_bus_bridge_pkg.sv
// Shared types and constants for the MSX slot I/O to internal bus bridge.
package msx_io_bus_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_RDATA,
    ST_HOLD
  } state_t;

  localparam logic [7:0]  c_default_rdata = 8'hFF;
  // Wide enough for the largest supported timeout (1023).
  localparam int unsigned c_cnt_w         = 10;

endpackage

// File: rtl/msx_slot_sync.sv
// Two-flop synchroniser for asynchronous Z80 slot strobes.
// The reset value is a parameter so that active-low strobes power up inactive.
module msx_slot_sync #(
  parameter int unsigned  W         = 1,
  parameter logic [W-1:0] RESET_VAL = '1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] i_async,
  output logic [W-1:0] o_sync
);

  logic [W-1:0] r_meta;
  logic [W-1:0] r_sync;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;

endmodule

// File: rtl/msx_io_bus_bridge.sv
// Turns one asynchronous Z80 slot I/O cycle into exactly one internal bus transaction,
// stretching the Z80 with WAIT_n until the peripheral answers or the timeout expires.
module msx_io_bus_bridge
  import msx_io_bus_bridge_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 128,
  parameter logic [7:0]  DEFAULT_RDATA  = c_default_rdata,
  parameter bit          USE_WAIT       = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       slot_iorq_n,
  input  logic       slot_rd_n,
  input  logic       slot_wr_n,
  input  logic       slot_m1_n,
  input  logic [7:0] slot_a,
  input  logic [7:0] slot_d_in,
  output logic [7:0] slot_d_out,
  output logic       slot_d_oe,
  output logic       slot_wait_n,
  output logic       bus_ioreq,
  output logic [7:0] bus_address,
  output logic       bus_write,
  output logic       bus_valid,
  input  logic       bus_ready,
  output logic [7:0] bus_wdata,
  input  logic [7:0] bus_rdata,
  input  logic       bus_rdata_en,
  output logic       timeout,
  output state_t     dbg_state
);

  localparam logic [c_cnt_w-1:0] c_timeout = c_cnt_w'(TIMEOUT_CYCLES);

  logic [3:0] w_sync_in;
  logic [3:0] w_sync_out;
  logic       s_iorq_n, s_rd_n, s_wr_n, s_m1_n;

  assign w_sync_in = {slot_m1_n, slot_wr_n, slot_rd_n, slot_iorq_n};

  msx_slot_sync #(.W(4), .RESET_VAL(4'hF)) u_sync (
    .clk     (clk),
    .reset   (reset),
    .i_async (w_sync_in),
    .o_sync  (w_sync_out)
  );

  assign {s_m1_n, s_wr_n, s_rd_n, s_iorq_n} = w_sync_out;

  state_t               r_state, w_state_nx;
  logic                 r_start_seen;
  logic                 r_valid, w_valid_nx;
  logic                 r_ioreq, w_ioreq_nx;
  logic                 r_write, w_write_nx;
  logic                 r_aborted, w_aborted_nx;
  logic [7:0]           r_addr, w_addr_nx;
  logic [7:0]           r_wdata, w_wdata_nx;
  logic [7:0]           r_dout, w_dout_nx;
  logic                 r_doe, w_doe_nx;
  logic                 r_timeout, w_timeout_nx;
  logic [c_cnt_w-1:0]   r_cnt, w_cnt_nx, w_cnt_inc;
  logic                 w_start_cond, w_strobe_active, w_pending, w_timeout_hit;

  assign w_strobe_active = !s_iorq_n && !(s_rd_n && s_wr_n);
  assign w_start_cond    = !s_iorq_n && s_m1_n && (s_rd_n != s_wr_n);
  assign w_pending       = (r_state == ST_REQ) || (r_state == ST_RDATA);
  assign w_cnt_inc       = r_cnt + c_cnt_w'(1);
  assign w_timeout_hit   = (w_cnt_inc == c_timeout);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_start_seen <= 1'b0;
      r_valid      <= 1'b0;
      r_ioreq      <= 1'b0;
      r_write      <= 1'b0;
      r_aborted    <= 1'b0;
      r_addr       <= 8'h00;
      r_wdata      <= 8'h00;
      r_dout       <= 8'hFF;
      r_doe        <= 1'b0;
      r_timeout    <= 1'b0;
      r_cnt        <= '0;
    end else begin
      r_state      <= w_state_nx;
      r_start_seen <= w_start_cond;
      r_valid      <= w_valid_nx;
      r_ioreq      <= w_ioreq_nx;
      r_write      <= w_write_nx;
      r_aborted    <= w_aborted_nx;
      r_addr       <= w_addr_nx;
      r_wdata      <= w_wdata_nx;
      r_dout       <= w_dout_nx;
      r_doe        <= w_doe_nx;
      r_timeout    <= w_timeout_nx;
      r_cnt        <= w_cnt_nx;
    end
  end

  // Handshake: bus_valid rises with the request and stays high until the first clock
  // edge that samples bus_ready=1; read data is accepted only on a bus_rdata_en strobe.
  always_comb begin
    w_state_nx   = r_state;
    w_valid_nx   = r_valid;
    w_ioreq_nx   = r_ioreq;
    w_write_nx   = r_write;
    w_aborted_nx = r_aborted;
    w_addr_nx    = r_addr;
    w_wdata_nx   = r_wdata;
    w_dout_nx    = r_dout;
    w_doe_nx     = 1'b0;
    w_timeout_nx = 1'b0;
    w_cnt_nx     = r_cnt;
    case (r_state)
      ST_IDLE: begin
        // Start must be seen on two consecutive synchronised cycles to reject glitches.
        if (w_start_cond && r_start_seen) begin
          w_state_nx   = ST_REQ;
          w_valid_nx   = 1'b1;
          w_ioreq_nx   = 1'b1;
          w_write_nx   = !s_wr_n;
          w_addr_nx    = slot_a;
          w_wdata_nx   = slot_d_in;
          w_aborted_nx = 1'b0;
          w_cnt_nx     = '0;
        end
      end
      ST_REQ, ST_RDATA: begin
        w_cnt_nx = w_cnt_inc;
        if (!w_strobe_active) w_aborted_nx = 1'b1;
        if (w_timeout_hit) begin
          w_valid_nx   = 1'b0;
          w_ioreq_nx   = 1'b0;
          w_dout_nx    = DEFAULT_RDATA;
          w_timeout_nx = 1'b1;
          w_state_nx   = ST_HOLD;
        end else if (r_state == ST_REQ) begin
          if (bus_ready) begin
            w_valid_nx = 1'b0;
            if (r_write) begin
              w_ioreq_nx = 1'b0;
              w_state_nx = ST_HOLD;
            end else if (bus_rdata_en) begin
              w_dout_nx  = bus_rdata;
              w_ioreq_nx = 1'b0;
              w_state_nx = ST_HOLD;
            end else begin
              w_state_nx = ST_RDATA;
            end
          end
        end else if (bus_rdata_en) begin
          w_dout_nx  = bus_rdata;
          w_ioreq_nx = 1'b0;
          w_state_nx = ST_HOLD;
        end
      end
      ST_HOLD: begin
        // A cycle the Z80 already abandoned never drives the data bus.
        if (w_strobe_active) w_doe_nx = !r_write && !r_aborted && !s_rd_n;
        else                 w_state_nx = ST_IDLE;
      end
      default: w_state_nx = ST_IDLE;
    endcase
  end

  assign slot_wait_n = !(USE_WAIT && w_pending && w_strobe_active);
  assign slot_d_out  = r_dout;
  assign slot_d_oe   = r_doe;
  assign bus_ioreq   = r_ioreq;
  assign bus_address = r_addr;
  assign bus_write   = r_write;
  assign bus_valid   = r_valid;
  assign bus_wdata   = r_wdata;
  assign timeout     = r_timeout;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_msx_io_bus_bridge.sv
// Self-checking bench for msx_io_bus_bridge: Z80 slot driver, simple peripheral responder,
// transaction scoreboard and a cycle-level model of how long the Z80 is held.
module tb_msx_io_bus_bridge;
  import msx_io_bus_bridge_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       slot_iorq_n, slot_rd_n, slot_wr_n, slot_m1_n;
  logic [7:0] slot_a, slot_d_in, slot_d_out;
  logic       slot_d_oe, slot_wait_n;
  logic       bus_ioreq, bus_write, bus_valid, bus_ready, bus_rdata_en, timeout;
  logic [7:0] bus_address, bus_wdata, bus_rdata;
  state_t     dbg_state;

  msx_io_bus_bridge dut (
    .clk          (clk),
    .reset        (reset),
    .slot_iorq_n  (slot_iorq_n),
    .slot_rd_n    (slot_rd_n),
    .slot_wr_n    (slot_wr_n),
    .slot_m1_n    (slot_m1_n),
    .slot_a       (slot_a),
    .slot_d_in    (slot_d_in),
    .slot_d_out   (slot_d_out),
    .slot_d_oe    (slot_d_oe),
    .slot_wait_n  (slot_wait_n),
    .bus_ioreq    (bus_ioreq),
    .bus_address  (bus_address),
    .bus_write    (bus_write),
    .bus_valid    (bus_valid),
    .bus_ready    (bus_ready),
    .bus_wdata    (bus_wdata),
    .bus_rdata    (bus_rdata),
    .bus_rdata_en (bus_rdata_en),
    .timeout      (timeout),
    .dbg_state    (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int n_cmp = 0;
  int n_err = 0;

  // ---------------- peripheral responder ----------------
  bit         rsp_on = 1'b0;
  int         rsp_ready_dly = 0;
  int         rsp_rdata_dly = 0;
  logic [7:0] rsp_data = 8'h00;
  int         rsp_cnt = 0;
  bit         rsp_phase = 1'b0;

  initial begin
    bus_ready = 1'b0; bus_rdata_en = 1'b0; bus_rdata = 8'h00;
    forever begin
      @(negedge clk);
      bus_ready = 1'b0; bus_rdata_en = 1'b0;
      if (!rsp_on || reset) begin
        rsp_phase = 1'b0; rsp_cnt = 0;
      end else if (!rsp_phase) begin
        if (bus_valid === 1'b1) begin
          if (rsp_cnt == rsp_ready_dly) begin
            bus_ready = 1'b1; rsp_cnt = 0;
            if (!bus_write) begin
              if (rsp_rdata_dly == 0) begin bus_rdata_en = 1'b1; bus_rdata = rsp_data; end
              else rsp_phase = 1'b1;
            end
          end else rsp_cnt++;
        end
      end else begin
        rsp_cnt++;
        if (rsp_cnt == rsp_rdata_dly) begin
          bus_rdata_en = 1'b1; bus_rdata = rsp_data; rsp_phase = 1'b0; rsp_cnt = 0;
        end
      end
    end
  end

  // ---------------- monitors / scoreboard ----------------
  logic [16:0] exp_q[$];
  logic [16:0] obs_q[$];
  int   cyc = 0, txn_cnt = 0, valid_cnt = 0, wait_low_cnt = 0, doe_cnt = 0, tmo_cnt = 0;
  int   valid_rise_cyc = 0, tmo_cyc = 0;
  logic prev_valid = 1'b0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    prev_valid <= bus_valid;
    if (bus_valid === 1'b1 && prev_valid !== 1'b1) begin
      txn_cnt <= txn_cnt + 1; valid_rise_cyc <= cyc;
    end
    if (bus_valid === 1'b1) valid_cnt <= valid_cnt + 1;
    if (slot_wait_n === 1'b0) wait_low_cnt <= wait_low_cnt + 1;
    if (slot_d_oe === 1'b1) doe_cnt <= doe_cnt + 1;
    if (timeout === 1'b1) begin tmo_cnt <= tmo_cnt + 1; tmo_cyc <= cyc; end
  end

  always @(posedge clk)
    if (!reset && bus_valid === 1'b1 && bus_ready === 1'b1)
      obs_q.push_back({bus_write, bus_address, bus_wdata});

  // ---------------- Z80 driver ----------------
  task automatic z80_cycle(input bit wr, input logic [7:0] a, input logic [7:0] d,
                           output bit ok, output logic [7:0] rd_val, output logic rd_oe,
                           output logic oe_rel);
    int n;
    @(negedge clk);
    slot_a = a; slot_d_in = d; slot_m1_n = 1'b1;
    slot_iorq_n = 1'b0; slot_rd_n = wr; slot_wr_n = !wr;
    repeat (4) @(negedge clk);
    n = 0;
    while (slot_wait_n === 1'b0 && n < 2000) begin @(negedge clk); n++; end
    ok = (n < 2000);
    repeat (2) @(negedge clk);
    rd_val = slot_d_out; rd_oe = slot_d_oe;
    slot_iorq_n = 1'b1; slot_rd_n = 1'b1; slot_wr_n = 1'b1;
    repeat (3) @(negedge clk);
    oe_rel = slot_d_oe;
    repeat (2) @(negedge clk);
  endtask

  task automatic clear_counts();
    @(negedge clk);
    valid_cnt = 0; wait_low_cnt = 0; doe_cnt = 0; tmo_cnt = 0;
    exp_q.delete(); obs_q.delete();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [28:0] got, want;
    reset = 1'b1;
    slot_iorq_n = 1'b1; slot_rd_n = 1'b1; slot_wr_n = 1'b1; slot_m1_n = 1'b1;
    slot_a = 8'h00; slot_d_in = 8'h00;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    want = {1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'hFF, 1'b0, 1'b1, 1'b0};
    got  = {bus_valid, bus_ioreq, bus_write, bus_address, bus_wdata, slot_d_out, slot_d_oe,
            slot_wait_n, timeout};
    n_cmp++;
    if (got !== want) begin n_err++; $display("FAIL power_on_outputs got=%h want=%h", got, want); end
    n_cmp++;
    if (dbg_state !== ST_IDLE) begin n_err++; $display("FAIL power_on_state got=%0d want=%0d", dbg_state, ST_IDLE); end

    // Reset in the middle of a pending write with no responder.
    rsp_on = 1'b0;
    slot_a = 8'hA5; slot_d_in = 8'h3C; slot_iorq_n = 1'b0; slot_wr_n = 1'b0;
    repeat (6) @(negedge clk);
    n_cmp++;
    if (dbg_state !== ST_REQ || bus_valid !== 1'b1 || slot_wait_n !== 1'b0) begin
      n_err++; $display("FAIL pre_reset_req state=%0d valid=%b wait_n=%b want 1/1/0", dbg_state, bus_valid, slot_wait_n);
    end
    reset = 1'b1;
    @(negedge clk);
    got = {bus_valid, bus_ioreq, bus_write, bus_address, bus_wdata, slot_d_out, slot_d_oe,
           slot_wait_n, timeout};
    n_cmp++;
    if (got !== want) begin n_err++; $display("FAIL mid_req_reset_outputs got=%h want=%h", got, want); end
    n_cmp++;
    if (dbg_state !== ST_IDLE) begin n_err++; $display("FAIL mid_req_reset_state got=%0d want=%0d", dbg_state, ST_IDLE); end
    slot_iorq_n = 1'b1; slot_wr_n = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    n_cmp++;
    if (bus_valid !== 1'b0 || slot_wait_n !== 1'b1) begin
      n_err++; $display("FAIL post_reset_quiet valid=%b wait_n=%b want 0/1", bus_valid, slot_wait_n);
    end
  endtask

  task automatic test_write();
    bit ok; logic [7:0] rv; logic oe, oe_rel; int t0; logic [16:0] e, o;
    rsp_on = 1'b1; rsp_ready_dly = 3; rsp_rdata_dly = 0;
    clear_counts(); t0 = txn_cnt;
    exp_q.push_back({1'b1, 8'hB0, 8'h06});
    z80_cycle(1'b1, 8'hB0, 8'h06, ok, rv, oe, oe_rel);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL write_wait_bound got=stuck want=release"); end
    n_cmp++; if (valid_cnt !== 4) begin n_err++; $display("FAIL write_valid_len got=%0d want=4", valid_cnt); end
    n_cmp++; if (wait_low_cnt !== 4) begin n_err++; $display("FAIL write_wait_len got=%0d want=4", wait_low_cnt); end
    n_cmp++; if (txn_cnt - t0 !== 1) begin n_err++; $display("FAIL write_txn_count got=%0d want=1", txn_cnt - t0); end
    n_cmp++; if (oe !== 1'b0) begin n_err++; $display("FAIL write_no_oe got=%b want=0", oe); end
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL write_sb_size got=%0d want=%0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_cmp++; if (o !== e) begin n_err++; $display("FAIL write_sb got=%h want=%h", o, e); end
    end
  endtask

  task automatic test_read();
    bit ok; logic [7:0] rv; logic oe, oe_rel; int t0; logic [16:0] e, o;
    rsp_on = 1'b1; rsp_ready_dly = 1; rsp_rdata_dly = 2; rsp_data = 8'h5A;
    clear_counts(); t0 = txn_cnt;
    exp_q.push_back({1'b0, 8'hB1, 8'h00});
    z80_cycle(1'b0, 8'hB1, 8'h00, ok, rv, oe, oe_rel);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL read_wait_bound got=stuck want=release"); end
    n_cmp++; if (rv !== 8'h5A) begin n_err++; $display("FAIL read_data got=%h want=5a", rv); end
    n_cmp++; if (oe !== 1'b1) begin n_err++; $display("FAIL read_oe got=%b want=1", oe); end
    n_cmp++; if (oe_rel !== 1'b0) begin n_err++; $display("FAIL read_oe_release got=%b want=0", oe_rel); end
    n_cmp++; if (wait_low_cnt !== 4) begin n_err++; $display("FAIL read_wait_len got=%0d want=4", wait_low_cnt); end
    n_cmp++; if (txn_cnt - t0 !== 1) begin n_err++; $display("FAIL read_txn_count got=%0d want=1", txn_cnt - t0); end
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL read_sb_size got=%0d want=%0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_cmp++; if (o !== e) begin n_err++; $display("FAIL read_sb got=%h want=%h", o, e); end
    end
  endtask

  task automatic test_timeout();
    bit ok; logic [7:0] rv; logic oe, oe_rel;
    rsp_on = 1'b0;
    clear_counts();
    z80_cycle(1'b0, 8'h40, 8'h00, ok, rv, oe, oe_rel);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL tmo_wait_bound got=stuck want=release"); end
    n_cmp++; if (tmo_cnt !== 1) begin n_err++; $display("FAIL tmo_pulse_len got=%0d want=1", tmo_cnt); end
    n_cmp++; if (tmo_cyc - valid_rise_cyc !== 128) begin n_err++; $display("FAIL tmo_delay got=%0d want=128", tmo_cyc - valid_rise_cyc); end
    n_cmp++; if (rv !== 8'hFF) begin n_err++; $display("FAIL tmo_data got=%h want=ff", rv); end
    n_cmp++; if (oe !== 1'b1) begin n_err++; $display("FAIL tmo_oe got=%b want=1", oe); end
    n_cmp++; if (wait_low_cnt !== 128) begin n_err++; $display("FAIL tmo_wait_len got=%0d want=128", wait_low_cnt); end
    n_cmp++; if (bus_valid !== 1'b0 || bus_ioreq !== 1'b0) begin n_err++; $display("FAIL tmo_bus_idle valid=%b ioreq=%b want 0/0", bus_valid, bus_ioreq); end
    n_cmp++; if (obs_q.size() != 0) begin n_err++; $display("FAIL tmo_no_accept got=%0d want=0", obs_q.size()); end
  endtask

  task automatic test_ignored();
    int t0;
    rsp_on = 1'b1; rsp_ready_dly = 0; rsp_rdata_dly = 0;
    for (int k = 0; k < 3; k++) begin
      clear_counts(); t0 = txn_cnt;
      case (k)
        0: begin slot_m1_n = 1'b0; slot_iorq_n = 1'b0; slot_rd_n = 1'b0; repeat (10) @(negedge clk); end
        1: begin slot_iorq_n = 1'b0; slot_rd_n = 1'b0; slot_wr_n = 1'b0; repeat (10) @(negedge clk); end
        default: begin
          slot_rd_n = 1'b0; @(negedge clk);
          slot_iorq_n = 1'b0; @(negedge clk);
          slot_iorq_n = 1'b1; repeat (6) @(negedge clk);
        end
      endcase
      slot_m1_n = 1'b1; slot_iorq_n = 1'b1; slot_rd_n = 1'b1; slot_wr_n = 1'b1;
      repeat (6) @(negedge clk);
      n_cmp++; if (txn_cnt - t0 !== 0) begin n_err++; $display("FAIL ignore%0d_txn got=%0d want=0", k, txn_cnt - t0); end
      n_cmp++; if (wait_low_cnt !== 0) begin n_err++; $display("FAIL ignore%0d_wait got=%0d want=0", k, wait_low_cnt); end
      n_cmp++; if (dbg_state !== ST_IDLE) begin n_err++; $display("FAIL ignore%0d_state got=%0d want=%0d", k, dbg_state, ST_IDLE); end
    end
  endtask

  task automatic test_abort();
    bit ok; logic [7:0] rv; logic oe, oe_rel; int n; logic [16:0] e, o;
    rsp_on = 1'b1; rsp_ready_dly = 0; rsp_rdata_dly = 10; rsp_data = 8'h33;
    clear_counts();
    exp_q.push_back({1'b0, 8'hB3, 8'h00});
    slot_a = 8'hB3; slot_d_in = 8'h00; slot_iorq_n = 1'b0; slot_rd_n = 1'b0;
    repeat (6) @(negedge clk);
    n_cmp++; if (dbg_state !== ST_RDATA) begin n_err++; $display("FAIL abort_in_rdata got=%0d want=%0d", dbg_state, ST_RDATA); end
    slot_iorq_n = 1'b1; slot_rd_n = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (slot_wait_n !== 1'b1) begin n_err++; $display("FAIL abort_wait_release got=%b want=1", slot_wait_n); end
    n = 0;
    while (dbg_state !== ST_IDLE && n < 40) begin @(negedge clk); n++; end
    n_cmp++; if (n >= 40) begin n_err++; $display("FAIL abort_return_idle got=%0d want=%0d", dbg_state, ST_IDLE); end
    repeat (3) @(negedge clk);
    n_cmp++; if (doe_cnt !== 0) begin n_err++; $display("FAIL abort_no_oe got=%0d want=0", doe_cnt); end
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL abort_sb_size got=%0d want=%0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_cmp++; if (o !== e) begin n_err++; $display("FAIL abort_sb got=%h want=%h", o, e); end
    end
    // Following write must be handled normally.
    rsp_ready_dly = 1;
    clear_counts();
    exp_q.push_back({1'b1, 8'hB2, 8'h01});
    z80_cycle(1'b1, 8'hB2, 8'h01, ok, rv, oe, oe_rel);
    n_cmp++; if (wait_low_cnt !== 2) begin n_err++; $display("FAIL after_abort_wait got=%0d want=2", wait_low_cnt); end
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL after_abort_sb_size got=%0d want=%0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_cmp++; if (o !== e) begin n_err++; $display("FAIL after_abort_sb got=%h want=%h", o, e); end
    end
  endtask

  task automatic test_random();
    bit ok, wr; logic [7:0] a, d, rv; logic oe, oe_rel; int exp_wait; logic [16:0] e, o;
    rsp_on = 1'b1;
    for (int it = 0; it < 16; it++) begin
      wr = 1'($urandom_range(0, 1));
      a = 8'($urandom_range(0, 255)); d = 8'($urandom_range(0, 255));
      rsp_ready_dly = $urandom_range(0, 4); rsp_rdata_dly = $urandom_range(0, 3);
      rsp_data = 8'($urandom_range(0, 255));
      // The Z80 is held for the peripheral's response time plus the request cycle.
      exp_wait = rsp_ready_dly + 1 + (wr ? 0 : rsp_rdata_dly);
      clear_counts();
      exp_q.push_back({wr, a, d});
      z80_cycle(wr, a, d, ok, rv, oe, oe_rel);
      n_cmp++; if (wait_low_cnt !== exp_wait) begin n_err++; $display("FAIL rnd%0d_wait got=%0d want=%0d", it, wait_low_cnt, exp_wait); end
      n_cmp++; if (oe !== !wr) begin n_err++; $display("FAIL rnd%0d_oe got=%b want=%b", it, oe, !wr); end
      if (!wr) begin
        n_cmp++; if (rv !== rsp_data) begin n_err++; $display("FAIL rnd%0d_rdata got=%h want=%h", it, rv, rsp_data); end
      end
      n_cmp++;
      if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL rnd%0d_sb_size got=%0d want=%0d", it, obs_q.size(), exp_q.size()); end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
        e = exp_q.pop_front(); o = obs_q.pop_front();
        n_cmp++; if (o !== e) begin n_err++; $display("FAIL rnd%0d_sb got=%h want=%h", it, o, e); end
      end
    end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    test_reset();
    test_write();
    test_read();
    test_timeout();
    test_ignored();
    test_abort();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
